// File: rtl/inst_fetch.sv
// Instruction fetch: PC generation, pipelined instruction-bus requests and a prefetch FIFO
// toward decode. Optional misaligned-jump fault is enabled by defining IFU_MISALIGN_CHK_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        fetch_en_i,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
`ifdef IFU_MISALIGN_CHK_EN
  output logic        fetch_fault_o,
  output logic [31:0] fault_addr_o,
`endif
  output logic [1:0]  fsm_state_o
);

  // Handshakes: a bus request is accepted on a cycle with ibus_req_o & ibus_gnt_i, and an
  // instruction moves to decode on inst_valid_o & id_ready_i; neither side waits on the other.
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [AW-1:0] AQ_LAST = AW'(MAX_OUTSTANDING - 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic          req_q, req_nxt;
  logic [31:0]   pc_q;
  logic [OW-1:0] live_q, live_nxt, stale_q, stale_nxt;
  logic [FW-1:0] cnt_q, cnt_nxt;
  logic [PW-1:0] rd_q, wr_q;
  logic [AW-1:0] aq_rd_q, aq_wr_q;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_addr [FIFO_DEPTH];
  logic [31:0]   aq_mem    [MAX_OUTSTANDING];

  logic        flush, grant, issue, resp_live, resp_any, push, pop;
  logic [31:0] jump_target;

  function automatic logic [AW-1:0] aq_inc(input logic [AW-1:0] p);
    return (p == AQ_LAST) ? '0 : p + AW'(1);
  endfunction

`ifdef IFU_MISALIGN_CHK_EN
  logic        jump_misaligned;
  logic        fault_q;
  logic [31:0] fault_addr_q;
  assign jump_misaligned = ex_jump_flag_i && (ex_jump_addr_i[1:0] != 2'b00);
  assign jump_target     = ex_jump_addr_i;
  assign fetch_fault_o   = fault_q;
  assign fault_addr_o    = fault_addr_q;
`else
  assign jump_target = ex_jump_addr_i & ~32'h3;
`endif

  assign flush        = ex_jump_flag_i;
  assign grant        = req_q && ibus_gnt_i;
  assign issue        = grant && !flush;
  // A response belongs to a stale request first; only once those drain is it live.
  assign resp_live    = ibus_rvalid_i && (stale_q == '0) && (live_q != '0);
  assign resp_any     = ibus_rvalid_i && ((stale_q != '0) || (live_q != '0));
  assign inst_valid_o = (cnt_q != '0);
  assign push         = resp_live && !flush;
  assign pop          = inst_valid_o && id_ready_i && !flush;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (fetch_en_i) state_nxt = RUN;
      RUN:     if (!fetch_en_i) state_nxt = IDLE;
      default: state_nxt = state_q;
    endcase
`ifdef IFU_MISALIGN_CHK_EN
    if (ex_jump_flag_i) state_nxt = jump_misaligned ? FAULT : (fetch_en_i ? RUN : IDLE);
`endif
  end

  always_comb begin
    if (flush) begin
      live_nxt  = '0;
      stale_nxt = stale_q + live_q + OW'(grant) - OW'(resp_any);
      cnt_nxt   = '0;
    end else begin
      live_nxt  = live_q + OW'(grant) - OW'(resp_live);
      stale_nxt = stale_q - OW'(ibus_rvalid_i && (stale_q != '0));
      cnt_nxt   = cnt_q + FW'(push) - FW'(pop);
    end
    // Request credit is evaluated on next-cycle values so ibus_req_o can be a flop.
    req_nxt = (state_nxt == RUN) &&
              (32'(live_nxt) + 32'(cnt_nxt) < 32'(FIFO_DEPTH)) &&
              (32'(live_nxt) + 32'(stale_nxt) < 32'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      live_q  <= '0;
      stale_q <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      aq_rd_q <= '0;
      aq_wr_q <= '0;
`ifdef IFU_MISALIGN_CHK_EN
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      req_q   <= req_nxt;
      live_q  <= live_nxt;
      stale_q <= stale_nxt;
      cnt_q   <= cnt_nxt;
      if (flush)      pc_q <= jump_target;
      else if (grant) pc_q <= pc_q + 32'd4;
      if (flush) begin
        rd_q    <= '0;
        wr_q    <= '0;
        aq_rd_q <= '0;
        aq_wr_q <= '0;
      end else begin
        if (push) begin
          wr_q    <= wr_q + PW'(1);
          aq_rd_q <= aq_inc(aq_rd_q);
        end
        if (pop)   rd_q    <= rd_q + PW'(1);
        if (issue) aq_wr_q <= aq_inc(aq_wr_q);
      end
`ifdef IFU_MISALIGN_CHK_EN
      if (flush) begin
        fault_q <= jump_misaligned;
        if (jump_misaligned) fault_addr_q <= ex_jump_addr_i;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_q] <= ibus_rdata_i;
      fifo_addr[wr_q] <= aq_mem[aq_rd_q];
    end
    if (issue) aq_mem[aq_wr_q] <= pc_q;
  end

  assign ibus_req_o  = req_q;
  assign ibus_addr_o = pc_q;
  assign inst_o      = inst_valid_o ? fifo_data[rd_q] : NOP;
  assign inst_addr_o = inst_valid_o ? fifo_addr[rd_q] : '0;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of requests, responses and the prefetch FIFO.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC        = 32'h0000_0000;
  localparam int          FIFO_DEPTH      = 2;
  localparam int          MAX_OUTSTANDING = 2;
  localparam logic [31:0] NOP             = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en_i = 1'b0, ex_jump_flag_i = 1'b0, ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0, id_ready_i = 1'b0;
  logic [31:0] ex_jump_addr_i = '0, ibus_rdata_i = '0;
  logic        ibus_req_o, inst_valid_o;
  logic [31:0] ibus_addr_o, inst_o, inst_addr_o;
  logic [1:0]  fsm_state_o;
`ifdef IFU_MISALIGN_CHK_EN
  logic        fetch_fault_o;
  logic [31:0] fault_addr_o;
`endif

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .fetch_en_i(fetch_en_i),
    .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_valid_o(inst_valid_o), .id_ready_i(id_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
`ifdef IFU_MISALIGN_CHK_EN
    .fetch_fault_o(fetch_fault_o), .fault_addr_o(fault_addr_o),
`endif
    .fsm_state_o(fsm_state_o)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  int dly_min = 1, dly_max = 1;
  logic        s_fetch_en = 0, s_gnt = 0, s_jump = 0, s_ready = 0;
  logic [31:0] s_jaddr = '0;

  // bus environment: granted addresses waiting to be answered
  logic [31:0] bus_addr_q[$];
  int          bus_due_q[$];
  // observations for directed literal checks
  logic [31:0] gnt_addr_q[$];
  logic [31:0] acc_addr_q[$];
  // model: outstanding requests in order (address, stale flag) and the prefetch FIFO
  logic [31:0] m_pc;
  logic        m_run, m_fault;
  logic [31:0] m_fault_addr;
  logic [31:0] m_out_addr[$];
  logic        m_out_stale[$];
  logic [31:0] m_fifo_data[$];
  logic [31:0] m_fifo_addr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int m_live();
    int n = 0;
    foreach (m_out_stale[i]) if (!m_out_stale[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] gnt_at(input int i);
    return (i < gnt_addr_q.size()) ? gnt_addr_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_addr_q.size()) ? acc_addr_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {fetch_en_i, ex_jump_flag_i, ibus_gnt_i, ibus_rvalid_i, id_ready_i} = '0;
    ex_jump_addr_i = '0;
    {s_fetch_en, s_gnt, s_jump, s_ready} = '0;
    s_jaddr = '0;
    bus_addr_q.delete(); bus_due_q.delete(); gnt_addr_q.delete(); acc_addr_q.delete();
    m_out_addr.delete(); m_out_stale.delete(); m_fifo_data.delete(); m_fifo_addr.delete();
    m_pc = RESET_PC; m_run = 0; m_fault = 0; m_fault_addr = '0;
    first_valid_cyc = -1;
    cyc = 0;
    repeat (2) @(negedge clk);
    check("rst_req", ibus_req_o, 1'b0);
    check("rst_addr", ibus_addr_o, RESET_PC);
    check("rst_valid", inst_valid_o, 1'b0);
    check("rst_inst", inst_o, NOP);
    check("rst_inst_addr", inst_addr_o, 32'h0);
    check("rst_state", fsm_state_o, 2'b00);
`ifdef IFU_MISALIGN_CHK_EN
    check("rst_fault", fetch_fault_o, 1'b0);
    check("rst_fault_addr", fault_addr_o, 32'h0);
`endif
    rst_n = 1'b1;
  endtask

  // One cycle: compare outputs with the model, drive the knobs, advance the model.
  task automatic step();
    logic exp_req, exp_valid, rv, st;
    logic [31:0] a;
    @(negedge clk);
    exp_req   = m_run && !m_fault && (m_live() + m_fifo_data.size() < FIFO_DEPTH) &&
                (m_out_addr.size() < MAX_OUTSTANDING);
    exp_valid = (m_fifo_data.size() != 0);
    check("ibus_req", ibus_req_o, exp_req);
    check("ibus_addr", ibus_addr_o, m_pc);
    check("inst_valid", inst_valid_o, exp_valid);
    check("inst", inst_o, exp_valid ? m_fifo_data[0] : NOP);
    if (exp_valid) check("inst_addr", inst_addr_o, m_fifo_addr[0]);
`ifdef IFU_MISALIGN_CHK_EN
    check("fetch_fault", fetch_fault_o, m_fault);
    check("fault_addr", fault_addr_o, m_fault_addr);
`endif
    fetch_en_i     = s_fetch_en;
    ibus_gnt_i     = s_gnt;
    ex_jump_flag_i = s_jump;
    ex_jump_addr_i = s_jaddr;
    id_ready_i     = s_ready;
    rv = (bus_due_q.size() != 0) && (bus_due_q[0] <= cyc);
    ibus_rvalid_i = rv;
    ibus_rdata_i  = rv ? mem_word(bus_addr_q[0]) : $urandom;
    if (rv) begin
      void'(bus_addr_q.pop_front());
      void'(bus_due_q.pop_front());
    end
    if (ibus_req_o && ibus_gnt_i) begin
      bus_addr_q.push_back(ibus_addr_o);
      bus_due_q.push_back(cyc + $urandom_range(dly_min, dly_max));
      gnt_addr_q.push_back(ibus_addr_o);
    end
    if (inst_valid_o && id_ready_i && !s_jump) acc_addr_q.push_back(inst_addr_o);
    if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;

    if (exp_valid && s_ready && !s_jump) begin
      void'(m_fifo_data.pop_front());
      void'(m_fifo_addr.pop_front());
    end
    if (rv) begin
      if (m_out_addr.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid_without_request: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        a  = m_out_addr.pop_front();
        st = m_out_stale.pop_front();
        if (!st && !s_jump) begin
          m_fifo_data.push_back(mem_word(a));
          m_fifo_addr.push_back(a);
        end
      end
    end
    if (exp_req && s_gnt) begin
      m_out_addr.push_back(m_pc);
      m_out_stale.push_back(s_jump);
      m_pc = m_pc + 32'd4;
    end
    if (s_jump) begin
      m_fifo_data.delete();
      m_fifo_addr.delete();
      foreach (m_out_stale[i]) m_out_stale[i] = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
      m_pc    = s_jaddr;
      m_fault = (s_jaddr[1:0] != 2'b00);
      if (m_fault) m_fault_addr = s_jaddr;
`else
      m_pc = s_jaddr & ~32'h3;
`endif
    end
    m_run = s_fetch_en;
    cyc++;
  endtask

  task automatic drv(input logic fe, input logic g, input logic j, input logic [31:0] ja,
                     input logic r);
    s_fetch_en = fe; s_gnt = g; s_jump = j; s_jaddr = ja; s_ready = r;
    step();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    // streaming start-up
    dly_min = 1; dly_max = 1;
    do_reset();
    repeat (10) drv(1, 1, 0, 0, 1);
    check("t1_gnt0", gnt_at(0), 32'h0);
    check("t1_gnt1", gnt_at(1), 32'h4);
    check("t1_gnt2", gnt_at(2), 32'h8);
    check("t1_acc0", acc_at(0), 32'h0);
    check("t1_acc1", acc_at(1), 32'h4);
    check("t1_acc2", acc_at(2), 32'h8);
    check("t1_first_valid_cycle", first_valid_cyc, 3);

    // decode stalled: credit caps requests at FIFO_DEPTH
    do_reset();
    repeat (10) drv(1, 1, 0, 0, 0);
    check("t2_grants", gnt_addr_q.size(), FIFO_DEPTH);
    check("t2_req_off", ibus_req_o, 1'b0);
    check("t2_inst_hold", inst_o, mem_word(32'h0));
    check("t2_inst_addr_hold", inst_addr_o, 32'h0);
    repeat (6) drv(1, 1, 0, 0, 1);
    check("t2_resume_addr", gnt_at(2), 32'h8);

    // jump with two requests in flight
    dly_min = 6; dly_max = 6;
    do_reset();
    drv(0, 0, 1, 32'h10, 1);
    repeat (4) drv(1, 1, 0, 0, 1);
    drv(1, 1, 1, 32'h100, 1);
    drv(1, 1, 0, 0, 1);
    check("t3_addr_after_jump", ibus_addr_o, 32'h100);
    repeat (20) drv(1, 1, 0, 0, 1);
    check("t3_gnt0", gnt_at(0), 32'h10);
    check("t3_gnt1", gnt_at(1), 32'h14);
    check("t3_gnt2", gnt_at(2), 32'h100);
    check("t3_first_acc", acc_at(0), 32'h100);

    // jump coinciding with a grant and a pop
    dly_min = 1; dly_max = 1;
    do_reset();
    drv(0, 0, 1, 32'h1C, 0);
    drv(1, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(1, 1, 1, 32'h40, 1);
    check("t4_req_at_jump", ibus_req_o, 1'b1);
    check("t4_addr_at_jump", ibus_addr_o, 32'h20);
    check("t4_valid_at_jump", inst_valid_o, 1'b1);
    drv(1, 1, 0, 0, 1);
    check("t4_empty_after", inst_valid_o, 1'b0);
    check("t4_addr_after", ibus_addr_o, 32'h40);
    repeat (12) drv(1, 1, 0, 0, 1);
    check("t4_first_acc", acc_at(0), 32'h40);

    // grant stall, then fetch disabled mid-stall
    dly_min = 3; dly_max = 3;
    do_reset();
    drv(1, 1, 0, 0, 1);
    drv(1, 1, 0, 0, 1);
    drv(1, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 1);
    check("t5_req_held", ibus_req_o, 1'b1);
    check("t5_addr_held", ibus_addr_o, 32'h4);
    drv(0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 1);
    check("t5_req_dropped", ibus_req_o, 1'b0);
    repeat (5) drv(0, 0, 0, 0, 1);
    check("t5_inflight_delivered", acc_at(0), 32'h0);
    check("t5_grants", gnt_addr_q.size(), 1);

    // PC wraps past the top of the address space
    dly_min = 1; dly_max = 1;
    do_reset();
    drv(0, 0, 1, 32'hFFFF_FFFC, 1);
    repeat (6) drv(1, 1, 0, 0, 1);
    check("t7_wrap_gnt0", gnt_at(0), 32'hFFFF_FFFC);
    check("t7_wrap_gnt1", gnt_at(1), 32'h0);

`ifdef IFU_MISALIGN_CHK_EN
    // misaligned jump faults until an aligned jump
    do_reset();
    drv(0, 0, 1, 32'h102, 1);
    repeat (4) drv(1, 1, 0, 0, 1);
    check("t6_fault", fetch_fault_o, 1'b1);
    check("t6_fault_addr", fault_addr_o, 32'h102);
    check("t6_no_req", ibus_req_o, 1'b0);
    check("t6_no_grants", gnt_addr_q.size(), 0);
    drv(1, 1, 1, 32'h200, 1);
    repeat (6) drv(1, 1, 0, 0, 1);
    check("t6_fault_cleared", fetch_fault_o, 1'b0);
    check("t6_resume", gnt_at(0), 32'h200);
`endif

    // randomized traffic against the model
    dly_min = 1; dly_max = 4;
    do_reset();
    repeat (3000) begin
      logic [31:0] ja;
      ja = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
`ifdef IFU_MISALIGN_CHK_EN
      if ($urandom_range(0, 3) != 0) ja[1:0] = 2'b00;
`endif
      drv($urandom_range(0, 15) != 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 39) == 0, ja, $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
